ctrl_drain_ac1: RTL and testbench

Read-side sequencer for the AC1 accumulation register bank. After the datapath FSM has filled all Pa AC1 entries, it pulses `start`. This block then reads entries 0..Pa-1 in order and streams them to the output stage over a valid/ready handshake. When the last word is accepted it pulses `term_drain` back to the FSM, which uses it to leave the drain state.

---
 rtl/ctrl_drain_ac1.sv | 124 ++++++++++++
 tb/tb_ctrl_drain_ac1.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_drain_ac1.sv
// Drains Pa words from the AC1 bank in address order through a 2-entry output FIFO.
// Define CTRL_DRAIN_AC1_LAST_EN to add an out_last flag carried alongside each word.
module ctrl_drain_ac1 #(
    parameter int Pa = 8,
    parameter int W  = 16,
    localparam int AW = $clog2(Pa)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cnt_clear,
    output logic          ac1_rd_en,
    output logic [AW-1:0] ac1_rd_addr,
    input  logic [W-1:0]  ac1_rd_data,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          busy,
`ifdef CTRL_DRAIN_AC1_LAST_EN
    output logic          term_drain,
    output logic          out_last
`else
    output logic          term_drain
`endif
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [AW:0] PA_C   = (AW+1)'(Pa);
    localparam logic [AW:0] LAST_C = (AW+1)'(Pa - 1);

    state_t         state_q, state_d;
    logic [AW:0]    rd_idx;
    logic [AW:0]    acc_idx;
    logic           vld_p1;
    logic [W-1:0]   fifo_mem [2];
    logic [1:0]     fifo_cnt;
    logic           wr_ptr;
    logic           rd_ptr;
    logic           pop;
    logic           push;
    logic           last_acc;
    logic           room;
    logic [2:0]     slots;

    assign busy        = (state_q == DRAIN);
    assign out_valid   = (fifo_cnt != 2'd0);
    assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
    assign pop         = out_valid && out_ready;
    assign push        = vld_p1 && !cnt_clear;
    assign last_acc    = busy && pop && (acc_idx == LAST_C);
    // Entries the FIFO would hold after this cycle's pop, counting the read already in flight.
    assign slots       = {1'b0, fifo_cnt} + {2'b0, vld_p1} - {2'b0, pop};
    assign room        = (slots < 3'd2);
    assign ac1_rd_en   = busy && !cnt_clear && (rd_idx < PA_C) && room;
    assign ac1_rd_addr = rd_idx[AW-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !cnt_clear) state_d = DRAIN;
            DRAIN:   if (cnt_clear || last_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CTRL_DRAIN_AC1_LAST_EN
    logic       last_p1;
    logic [1:0] last_mem;
    assign out_last = out_valid && last_mem[rd_ptr];
`endif

    // Stage p0 -> p1: read issue to data return; counters and FIFO control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_idx     <= '0;
            acc_idx    <= '0;
            fifo_cnt   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            vld_p1     <= 1'b0;
            term_drain <= 1'b0;
`ifdef CTRL_DRAIN_AC1_LAST_EN
            last_p1    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            term_drain <= last_acc && !cnt_clear;
            if (cnt_clear || !busy || last_acc) begin
                rd_idx   <= '0;
                acc_idx  <= '0;
                fifo_cnt <= '0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                vld_p1   <= 1'b0;
`ifdef CTRL_DRAIN_AC1_LAST_EN
                last_p1  <= 1'b0;
`endif
            end else begin
                vld_p1   <= ac1_rd_en;
                rd_idx   <= rd_idx + {{AW{1'b0}}, ac1_rd_en};
                acc_idx  <= acc_idx + {{AW{1'b0}}, pop};
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
`ifdef CTRL_DRAIN_AC1_LAST_EN
                last_p1  <= ac1_rd_en && (rd_idx == LAST_C);
`endif
            end
        end
    end

    // Stage p1 -> FIFO: returning bank data captured into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ac1_rd_data;
`ifdef CTRL_DRAIN_AC1_LAST_EN
            last_mem[wr_ptr] <= last_p1;
`endif
        end
    end

endmodule

// File: tb/tb_ctrl_drain_ac1.sv
// Self-checking bench for ctrl_drain_ac1: emulated AC1 bank plus a transaction-level
// scoreboard of the expected word stream, read bound and term_drain timing.
module tb_ctrl_drain_ac1;

    localparam int PA = 8;
    localparam int DW = 16;
    localparam int AW = $clog2(PA);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cnt_clear = 1'b0;
    logic          ac1_rd_en;
    logic [AW-1:0] ac1_rd_addr;
    logic [DW-1:0] ac1_rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          term_drain;
`ifdef CTRL_DRAIN_AC1_LAST_EN
    logic          out_last;
`endif

    ctrl_drain_ac1 #(.Pa(PA), .W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cnt_clear   (cnt_clear),
        .ac1_rd_en   (ac1_rd_en),
        .ac1_rd_addr (ac1_rd_addr),
        .ac1_rd_data (ac1_rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
`ifdef CTRL_DRAIN_AC1_LAST_EN
        .term_drain  (term_drain),
        .out_last    (out_last)
`else
        .term_drain  (term_drain)
`endif
    );

    always #5 clk = ~clk;

    // AC1 bank: synchronous read, data one cycle after the strobe
    logic [DW-1:0] bank [PA];
    always @(posedge clk) if (ac1_rd_en) ac1_rd_data <= bank[ac1_rd_addr];

    int checks = 0;
    int errors = 0;

    // Scoreboard state
    bit            mon_en = 0;
    bit            m_busy = 0;
    int            m_reads = 0;
    int            m_acc = 0;
    bit            term_pending = 0;
    bit            held_valid = 0;
    logic [DW-1:0] held_data = '0;
    logic          last_valid, last_term, last_rd_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        bit was_busy;
        was_busy   = m_busy;
        last_valid = out_valid;
        last_term  = term_drain;
        last_rd_en = ac1_rd_en;
        chk("term_drain", term_drain, term_pending);
        chk("busy", busy, m_busy);
        if (!m_busy) chk("idle_quiet", {out_valid, ac1_rd_en}, 2'b00);
        if (held_valid) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held_data);
        end
        if (ac1_rd_en) begin
            chk("rd_addr", ac1_rd_addr, m_reads);
            m_reads++;
            chk("rd_bound", m_reads <= PA, 1);
        end
`ifdef CTRL_DRAIN_AC1_LAST_EN
        chk("out_last", out_last, out_valid && (m_acc == PA - 1));
`endif
        term_pending = 0;
        if (out_valid && out_ready) begin
            chk("out_data", out_data, bank[m_acc]);
            m_acc++;
            if (m_acc == PA) begin
                term_pending = 1;
                m_busy = 0;
            end
        end
        chk("outstanding", (m_reads - m_acc) <= 2, 1);
        held_valid = out_valid && !out_ready;
        held_data  = out_data;
        if (!was_busy && start) begin
            m_busy  = 1;
            m_reads = 0;
            m_acc   = 0;
        end
        if (cnt_clear || !rst_n) begin
            m_busy       = 0;
            m_reads      = 0;
            m_acc        = 0;
            held_valid   = 0;
            term_pending = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: alternate 1,0,..., 2: random
    task automatic drain(input int mode, input int max_cyc);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < max_cyc) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
            if (last_term) seen = 1;
        end
        chk("term_seen", seen, 1);
        chk("word_count", m_acc, PA);
    endtask

    task automatic load_seq();
        for (int k = 0; k < PA; k++) bank[k] = 16'h0100 + 16'(k);
    endtask

    task automatic load_rand();
        for (int k = 0; k < PA; k++) bank[k] = 16'($urandom);
    endtask

    initial begin
        int first_v, nval, term_c, npulse;
        load_seq();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rd_en", ac1_rd_en, 0);
        chk("rst_addr", ac1_rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_term", term_drain, 0);
        mon_en = 1;
        tick();

        // Full-rate drain with fixed contents and latency check
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        first_v = -1;
        nval = 0;
        term_c = -1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (last_valid) begin
                if (first_v < 0) first_v = c;
                nval++;
            end
            if (last_term && term_c < 0) term_c = c;
        end
        chk("first_latency", first_v, 3);
        chk("valid_cycles", nval, PA);
        chk("term_cycle", term_c, 11);

        // Alternating backpressure
        load_rand();
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        drain(1, 100);
        tick();

        // Long stall after start: only two reads may go out
        load_rand();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        npulse = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (last_rd_en) npulse++;
        end
        chk("stall_reads", npulse, 2);
        drain(0, 100);
        tick();

        // Abort mid-drain, then restart from address 0
        load_rand();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        tick();
        chk("clr_valid", last_valid, 0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(0, 100);

        // start with cnt_clear in IDLE, then a redundant start during DRAIN
        start = 1'b1;
        cnt_clear = 1'b1;
        tick();
        start = 1'b0;
        cnt_clear = 1'b0;
        tick();
        chk("sc_rd_en", last_rd_en, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(0, 100);
        tick();

        // Random backpressure runs
        for (int r = 0; r < 3; r++) begin
            load_rand();
            start = 1'b1;
            tick();
            start = 1'b0;
            drain(2, 300);
            tick();
        end

        // Reset mid-drain
        load_seq();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_rd_en", ac1_rd_en, 0);
        chk("mid_rst_addr", ac1_rd_addr, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_term", term_drain, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(2, 300);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
